// File: rtl/rega_multizona.sv
// rega_multizona: round-robin multi-zone irrigation controller with
// debounced sensors, run timeout, inter-zone pause and latched fault.
module rega_multizona #(
  parameter int N_ZONAS      = 4,
  parameter int DEB_CICLOS   = 8,
  parameter int RUN_MAX      = 1000,
  parameter int PAUSA_CICLOS = 16,
  localparam int ZW = $clog2(N_ZONAS)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_ZONAS-1:0] Us,
  input  logic               Ua,
  input  logic               T,
  input  logic               M,
  input  logic               L,
  input  logic               ERRO,
  input  logic               CLR,
  output logic [N_ZONAS-1:0] Bs,
  output logic [N_ZONAS-1:0] Vs,
  output logic [ZW-1:0]      ZONA,
  output logic               OCUPADO,
  output logic               FALHA
);

  localparam int NB = N_ZONAS + 4;
  localparam int DW = $clog2(DEB_CICLOS + 1);
  localparam int RW = $clog2(RUN_MAX + 1);
  localparam int PW = $clog2(PAUSA_CICLOS + 1);

  localparam logic [NB-1:0] RST_V    = {4'b0000, {N_ZONAS{1'b1}}};
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CICLOS - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_MAX - 1);
  localparam logic [PW-1:0] PAU_LAST = PW'(PAUSA_CICLOS - 1);

  typedef enum logic [2:0] {
    S_OCIOSO,
    S_SELECIONA,
    S_REGA,
    S_PAUSA,
    S_FALHA
  } st_t;

  st_t st, nxt;

  logic [NB-1:0] s1, s2, flt;
  logic [DW-1:0] cnt [NB];
  logic [1:0]    e_s, c_s;

  logic [N_ZONAS-1:0] us_f;
  logic               ua_f, t_f, m_f, l_f;
  logic               erro_s, clr_s;

  logic [ZW-1:0]      ptr, zona, sel, idx;
  logic               found, modo;
  logic [RW-1:0]      run_cnt;
  logic [PW-1:0]      pau_cnt;
  logic [N_ZONAS-1:0] oh;

  // Sensor vector layout: {L, M, T, Ua, Us}
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1  <= RST_V;
      s2  <= RST_V;
      e_s <= '0;
      c_s <= '0;
    end else begin
      s1  <= {L, M, T, Ua, Us};
      s2  <= s1;
      e_s <= {e_s[0], ERRO};
      c_s <= {c_s[0], CLR};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flt <= RST_V;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == flt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          flt[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign us_f   = flt[N_ZONAS-1:0];
  assign ua_f   = flt[N_ZONAS];
  assign t_f    = flt[N_ZONAS+1];
  assign m_f    = flt[N_ZONAS+2];
  assign l_f    = flt[N_ZONAS+3];
  assign erro_s = e_s[1];
  assign clr_s  = c_s[1];

  // First dry zone after the last one served, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= N_ZONAS; k++) begin
      idx = ZW'((int'(ptr) + k) % N_ZONAS);
      if (!found && !us_f[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    nxt = st;
    unique case (st)
      S_OCIOSO:
        if (l_f && !(&us_f)) nxt = S_SELECIONA;
      S_SELECIONA:
        nxt = (found && l_f) ? S_REGA : S_OCIOSO;
      S_REGA:
        if (us_f[zona] || !l_f || run_cnt == RUN_LAST)
          nxt = S_PAUSA;
      S_PAUSA:
        if (pau_cnt == PAU_LAST) nxt = S_OCIOSO;
      S_FALHA:
        if (!erro_s && clr_s) nxt = S_OCIOSO;
      default:
        nxt = S_OCIOSO;
    endcase
    if (erro_s) nxt = S_FALHA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st      <= S_OCIOSO;
      ptr     <= ZW'(N_ZONAS - 1);
      zona    <= '0;
      modo    <= 1'b0;
      run_cnt <= '0;
      pau_cnt <= '0;
    end else begin
      st <= nxt;
      if (st == S_SELECIONA && nxt == S_REGA) begin
        zona    <= sel;
        modo    <= (~t_f & m_f) | ~ua_f;
        run_cnt <= '0;
      end
      if (st == S_REGA && nxt == S_REGA)
        run_cnt <= run_cnt + 1'b1;
      if (st == S_REGA && nxt == S_PAUSA)
        ptr <= zona;
      if (st != S_PAUSA && nxt == S_PAUSA)
        pau_cnt <= '0;
      else if (st == S_PAUSA && nxt == S_PAUSA)
        pau_cnt <= pau_cnt + 1'b1;
    end
  end

  assign oh      = N_ZONAS'(1) << zona;
  assign Bs      = (st == S_REGA && modo)  ? oh : '0;
  assign Vs      = (st == S_REGA && !modo) ? oh : '0;
  assign ZONA    = zona;
  assign OCUPADO = (st == S_SELECIONA) || (st == S_REGA) ||
                   (st == S_PAUSA);
  assign FALHA   = (st == S_FALHA);

endmodule

// File: tb/tb_rega_multizona.sv
// tb_rega_multizona: directed bench for rega_multizona
// (N_ZONAS=4, DEB_CICLOS=4, RUN_MAX=20, PAUSA_CICLOS=5).
module tb_rega_multizona;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] Us = 4'b1111;
  logic       Ua = 1'b0;
  logic       T = 1'b0;
  logic       M = 1'b0;
  logic       L = 1'b0;
  logic       ERRO = 1'b0;
  logic       CLR = 1'b0;
  logic [3:0] Bs, Vs;
  logic [1:0] ZONA;
  logic       OCUPADO, FALHA;

  int passed = 0;
  int total = 0;

  rega_multizona #(
    .N_ZONAS(4),
    .DEB_CICLOS(4),
    .RUN_MAX(20),
    .PAUSA_CICLOS(5)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .Us(Us),
    .Ua(Ua),
    .T(T),
    .M(M),
    .L(L),
    .ERRO(ERRO),
    .CLR(CLR),
    .Bs(Bs),
    .Vs(Vs),
    .ZONA(ZONA),
    .OCUPADO(OCUPADO),
    .FALHA(FALHA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input logic [3:0] us, input logic l,
                          input logic ua, input logic t,
                          input logic m);
    @(negedge CLK);
    RST_N = 1'b0;
    Us = us; L = l; Ua = ua; T = t; M = m;
    ERRO = 1'b0; CLR = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic wait_run(input int budget, output int n);
    n = 0;
    while ((Bs | Vs) == 4'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if ((Bs | Vs) == 4'b0) n = -1;
  endtask

  task automatic count_on(output int n);
    n = 0;
    while ((Bs | Vs) != 4'b0 && n < 500) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic count_off(output int n);
    n = 0;
    while ((Bs | Vs) == 4'b0 && n < 500) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RST_N = 1'b0;
    Us = 4'b1111; L = 1'b0; Ua = 1'b0; T = 1'b0; M = 1'b0;
    #1;
    total++; if (Bs !== 4'b0 || Vs !== 4'b0)
      $display("FAIL rst_out: Bs=%b Vs=%b want 0000/0000", Bs, Vs);
    else passed++;
    total++; if (ZONA !== 2'd0)
      $display("FAIL rst_zona: got %0d want 0", ZONA);
    else passed++;
    total++; if (OCUPADO !== 1'b0 || FALHA !== 1'b0)
      $display("FAIL rst_flags: OCUPADO=%b FALHA=%b want 0/0",
               OCUPADO, FALHA);
    else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    total++; if (OCUPADO !== 1'b0 || (Bs | Vs) !== 4'b0)
      $display("FAIL rst_idle: OCUPADO=%b Bs|Vs=%b want 0/0000",
               OCUPADO, Bs | Vs);
    else passed++;
  endtask

  task automatic test_drip_timeout;
    int n;
    do_reset(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_run(40, n);
    total++; if (n < 0)
      $display("FAIL t1_start: no watering within 40 cycles");
    else passed++;
    total++; if (Vs !== 4'b0100 || Bs !== 4'b0)
      $display("FAIL t1_out: Vs=%b Bs=%b want 0100/0000", Vs, Bs);
    else passed++;
    total++; if (ZONA !== 2'd2 || OCUPADO !== 1'b1)
      $display("FAIL t1_zona: ZONA=%0d OCUPADO=%b want 2/1",
               ZONA, OCUPADO);
    else passed++;
    count_on(n);
    total++; if (n !== 20)
      $display("FAIL t1_run_len: got %0d want 20", n);
    else passed++;
    count_off(n);
    total++; if (n !== 7)
      $display("FAIL t1_gap_len: got %0d want 7", n);
    else passed++;
    total++; if (Vs !== 4'b0100 || Bs !== 4'b0 || ZONA !== 2'd2)
      $display("FAIL t1_again: Vs=%b Bs=%b ZONA=%0d want 0100/0000/2",
               Vs, Bs, ZONA);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int n, bad;
    bad = 0;
    do_reset(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_run(40, n);
    total++; if (Bs !== 4'b0001 || Vs !== 4'b0)
      $display("FAIL t2_first: Bs=%b Vs=%b want 0001/0000", Bs, Vs);
    else passed++;
    n = 0;
    while ((Bs | Vs) != 4'b0 && n < 500) begin
      if ((Bs & Vs) != 4'b0 || !$onehot0(Bs | Vs)) bad++;
      n++;
      @(negedge CLK);
    end
    total++; if (n !== 20)
      $display("FAIL t2_run_len: got %0d want 20", n);
    else passed++;
    count_off(n);
    total++; if (Bs !== 4'b1000 || ZONA !== 2'd3)
      $display("FAIL t2_second: Bs=%b ZONA=%0d want 1000/3", Bs, ZONA);
    else passed++;
    n = 0;
    while ((Bs | Vs) != 4'b0 && n < 500) begin
      if ((Bs & Vs) != 4'b0 || !$onehot0(Bs | Vs)) bad++;
      n++;
      @(negedge CLK);
    end
    count_off(n);
    total++; if (Bs !== 4'b0001 || ZONA !== 2'd0)
      $display("FAIL t2_third: Bs=%b ZONA=%0d want 0001/0", Bs, ZONA);
    else passed++;
    total++; if (bad !== 0)
      $display("FAIL t2_onehot: %0d bad samples want 0", bad);
    else passed++;
  endtask

  task automatic test_wet_exit;
    int n, bad;
    do_reset(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_run(40, n);
    total++; if (Bs !== 4'b0001)
      $display("FAIL t3_start: Bs=%b want 0001", Bs);
    else passed++;
    repeat (2) @(negedge CLK);
    Us = 4'b1111;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (Bs != 4'b0 && n < 30);
    total++; if (n !== 7)
      $display("FAIL t3_latency: got %0d want 7", n);
    else passed++;
    total++; if (OCUPADO !== 1'b1)
      $display("FAIL t3_pausa: OCUPADO=%b want 1", OCUPADO);
    else passed++;
    bad = 0;
    repeat (40) begin
      @(negedge CLK);
      if ((Bs | Vs) != 4'b0) bad++;
    end
    total++; if (bad !== 0 || OCUPADO !== 1'b0)
      $display("FAIL t3_idle: bad=%0d OCUPADO=%b want 0/0",
               bad, OCUPADO);
    else passed++;
  endtask

  task automatic test_mode_frozen;
    int n, bad;
    do_reset(4'b1110, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_run(40, n);
    total++; if (Vs !== 4'b0001 || Bs !== 4'b0)
      $display("FAIL t4_start: Vs=%b Bs=%b want 0001/0000", Vs, Bs);
    else passed++;
    n = 0;
    bad = 0;
    while ((Bs | Vs) != 4'b0 && n < 100) begin
      if (Bs != 4'b0 || Vs != 4'b0001) bad++;
      if (n < 8) begin
        T = ~T;
        M = ~M;
      end else begin
        T = 1'b0;
        M = 1'b1;
      end
      n++;
      @(negedge CLK);
    end
    total++; if (bad !== 0 || n !== 20)
      $display("FAIL t4_frozen: bad=%0d len=%0d want 0/20", bad, n);
    else passed++;
    count_off(n);
    total++; if (Bs !== 4'b0001 || Vs !== 4'b0)
      $display("FAIL t4_next_mode: Bs=%b Vs=%b want 0001/0000", Bs, Vs);
    else passed++;
    do_reset(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    bad = 0;
    repeat (60) begin
      @(negedge CLK);
      if ((Bs | Vs) != 4'b0 || OCUPADO != 1'b0) bad++;
    end
    total++; if (bad !== 0)
      $display("FAIL t4_no_level: %0d active samples want 0", bad);
    else passed++;
  endtask

  task automatic test_fault;
    int n, bad;
    do_reset(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_run(40, n);
    count_on(n);
    count_off(n);
    total++; if (Bs !== 4'b1000 || ZONA !== 2'd3)
      $display("FAIL t5_zone3: Bs=%b ZONA=%0d want 1000/3", Bs, ZONA);
    else passed++;
    repeat (3) @(negedge CLK);
    ERRO = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      ERRO = 1'b0;
    end while (FALHA != 1'b1 && n < 10);
    total++; if (n > 3)
      $display("FAIL t5_latency: FALHA after %0d cycles want <=3", n);
    else passed++;
    total++; if ((Bs | Vs) !== 4'b0 || OCUPADO !== 1'b0 ||
                 ZONA !== 2'd3)
      $display("FAIL t5_outs: Bs|Vs=%b OCUPADO=%b ZONA=%0d want 0000/0/3",
               Bs | Vs, OCUPADO, ZONA);
    else passed++;
    ERRO = 1'b1;
    CLR = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge CLK);
      if (FALHA != 1'b1 || (Bs | Vs) != 4'b0) bad++;
    end
    total++; if (bad !== 0)
      $display("FAIL t5_clr_ignored: %0d bad samples want 0", bad);
    else passed++;
    ERRO = 1'b0;
    CLR = 1'b0;
    repeat (5) @(negedge CLK);
    total++; if (FALHA !== 1'b1)
      $display("FAIL t5_latched: FALHA=%b want 1", FALHA);
    else passed++;
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    wait_run(20, n);
    total++; if (n < 0 || FALHA !== 1'b0)
      $display("FAIL t5_recover: wait=%0d FALHA=%b want >=0/0", n, FALHA);
    else passed++;
    total++; if (Bs !== 4'b1000 || ZONA !== 2'd3)
      $display("FAIL t5_ptr: Bs=%b ZONA=%0d want 1000/3", Bs, ZONA);
    else passed++;
  endtask

  task automatic test_async_reset;
    int n;
    do_reset(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_run(40, n);
    count_on(n);
    count_off(n);
    repeat (2) @(negedge CLK);
    total++; if (Bs !== 4'b1000)
      $display("FAIL t6_pre: Bs=%b want 1000", Bs);
    else passed++;
    #2;
    RST_N = 1'b0;
    #1;
    total++; if ((Bs | Vs) !== 4'b0 || OCUPADO !== 1'b0 ||
                 FALHA !== 1'b0 || ZONA !== 2'd0)
      $display("FAIL t6_async: Bs|Vs=%b OCUPADO=%b FALHA=%b ZONA=%0d want 0000/0/0/0",
               Bs | Vs, OCUPADO, FALHA, ZONA);
    else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    wait_run(40, n);
    total++; if (Bs !== 4'b0001 || ZONA !== 2'd0)
      $display("FAIL t6_first: Bs=%b ZONA=%0d want 0001/0", Bs, ZONA);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_drip_timeout();
    test_back_to_back();
    test_wet_exit();
    test_mode_frozen();
    test_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
